// File: rtl/ad9958_reg_writer_if.sv
// Command handshake between the sequencing logic (master) and the AD9958 register writer (slave).
interface ad9958_reg_writer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_update;

  modport master (output cmd_valid, cmd_addr, cmd_data, cmd_update, input cmd_ready);
  modport slave  (input cmd_valid, cmd_addr, cmd_data, cmd_update, output cmd_ready);
endinterface

// File: rtl/ad9958_reg_writer.sv
// Turns one AD9958 register write into an instruction+data nibble frame for spi_send_only,
// waits for the transfer to finish and optionally pulses IO_UPDATE.
module ad9958_reg_writer #(
  parameter bit NIBBLE_LSB_FIRST = 1'b1,
  parameter int BUSY_TIMEOUT     = 16,
  parameter int IOUPD_CYCLES     = 4,
  parameter int GAP_CYCLES       = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  ad9958_reg_writer_if.slave        cmd,
  output logic [63:0]               spi_data,
  output logic [4:0]                spi_packs,
  output logic                      spi_trigger,
  input  logic                      spi_busy,
  output logic                      io_update,
  output logic                      done,
  output logic                      err
);

  typedef enum logic [2:0] {IDLE, LOAD, TRIG, WAIT_BUSY, WAIT_DONE, IOUPD, GAP} state_t;

  state_t        state_reg, state_next;
  logic [15:0]   cnt_reg, cnt_next;
  logic          update_reg, update_next;
  logic          fail_reg, fail_next;
  logic [63:0]   data_reg, data_next;
  logic [4:0]    packs_reg, packs_next;
  logic          armed_reg;
  logic          trigger_reg;

  logic          accept;
  logic          bad_addr;
  logic [2:0]    n_bytes;
  logic [3:0][7:0] data_bytes;
  logic [4:0][7:0] frame_byte;
  logic [9:0][3:0] nibble;
  logic [4:0]    frame_packs;
  logic [63:0]   frame;

  function automatic logic [2:0] byte_count(input logic [4:0] addr);
    case (addr)
      5'h00:   byte_count = 3'd1;
      5'h01:   byte_count = 3'd3;
      5'h02:   byte_count = 3'd2;
      5'h03:   byte_count = 3'd3;
      5'h04:   byte_count = 3'd4;
      5'h05:   byte_count = 3'd2;
      5'h06:   byte_count = 3'd3;
      5'h07:   byte_count = 3'd2;
      default: byte_count = 3'd4;
    endcase
  endfunction

  assign accept      = cmd.cmd_valid & cmd.cmd_ready;
  assign bad_addr    = cmd.cmd_addr > 5'h18;
  assign n_bytes     = byte_count(cmd.cmd_addr);
  assign data_bytes  = cmd.cmd_data;
  assign frame_packs = {1'b0, n_bytes, 1'b0} + 5'd2;

  // Byte 0 is the write instruction; data bytes follow most-significant first.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_byte
      if (gi == 0) begin : g_instr
        assign frame_byte[gi] = {3'b000, cmd.cmd_addr};
      end else begin : g_data
        logic [2:0] idx;
        assign idx            = n_bytes - 3'(gi);
        assign frame_byte[gi] = (3'(gi) <= n_bytes) ? data_bytes[idx[1:0]] : 8'h00;
      end
    end
    for (gi = 0; gi < 10; gi++) begin : g_nibble
      if (gi % 2 == 0) begin : g_hi
        assign nibble[gi] = (5'(gi) < frame_packs) ? frame_byte[gi/2][7:4] : 4'h0;
      end else begin : g_lo
        assign nibble[gi] = (5'(gi) < frame_packs) ? frame_byte[gi/2][3:0] : 4'h0;
      end
    end
  endgenerate

  always_comb begin
    frame = '0;
    for (int k = 0; k < 10; k++) begin
      if (NIBBLE_LSB_FIRST) frame[4*k +: 4]      = nibble[k];
      else                  frame[60 - 4*k +: 4] = nibble[k];
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    update_next = update_reg;
    fail_next   = fail_reg;
    data_next   = data_reg;
    packs_next  = packs_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          update_next = cmd.cmd_update;
          cnt_next    = '0;
          if (bad_addr) begin
            fail_next  = 1'b1;
            state_next = GAP;
          end else begin
            fail_next  = 1'b0;
            data_next  = frame;
            packs_next = frame_packs;
            state_next = LOAD;
          end
        end
      end
      LOAD: state_next = TRIG;
      TRIG: begin
        cnt_next   = '0;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (spi_busy) begin
          state_next = WAIT_DONE;
        end else if (cnt_reg == 16'(BUSY_TIMEOUT - 1)) begin
          fail_next  = 1'b1;
          cnt_next   = '0;
          data_next  = '0;
          packs_next = '0;
          state_next = GAP;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      WAIT_DONE: begin
        if (!spi_busy) begin
          cnt_next   = '0;
          data_next  = '0;
          packs_next = '0;
          state_next = update_reg ? IOUPD : GAP;
        end
      end
      IOUPD: begin
        if (cnt_reg == 16'(IOUPD_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = GAP;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      GAP: begin
        if (cnt_reg == 16'(GAP_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Trigger is registered from TRIG so it lands two cycles after the accept edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      update_reg  <= 1'b0;
      fail_reg    <= 1'b0;
      data_reg    <= '0;
      packs_reg   <= '0;
      armed_reg   <= 1'b0;
      trigger_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      update_reg  <= update_next;
      fail_reg    <= fail_next;
      data_reg    <= data_next;
      packs_reg   <= packs_next;
      armed_reg   <= 1'b1;
      trigger_reg <= (state_reg == TRIG);
    end
  end

  assign cmd.cmd_ready = armed_reg && (state_reg == IDLE);
  assign spi_data      = data_reg;
  assign spi_packs     = packs_reg;
  assign spi_trigger   = trigger_reg;
  assign io_update     = (state_reg == IOUPD);
  assign err           = (state_reg == GAP) && (cnt_reg == 16'd0) && fail_reg;
  assign done          = (state_reg == GAP) && (cnt_reg == 16'(GAP_CYCLES - 1)) && !fail_reg;

endmodule

// File: tb/tb_ad9958_reg_writer.sv
// Scoreboard bench: expected frames queued at command issue, checked when spi_trigger fires.
module tb_ad9958_reg_writer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ad9958_reg_writer_if cif0();
  ad9958_reg_writer_if cif1();

  logic [63:0] spi_data0, spi_data1;
  logic [4:0]  spi_packs0, spi_packs1;
  logic        spi_trigger0, spi_trigger1;
  logic        spi_busy0 = 1'b0, spi_busy1 = 1'b0;
  logic        io_update0, io_update1, done0, done1, err0, err1;

  ad9958_reg_writer dut0 (
    .clock(clock), .reset(reset), .cmd(cif0),
    .spi_data(spi_data0), .spi_packs(spi_packs0), .spi_trigger(spi_trigger0),
    .spi_busy(spi_busy0), .io_update(io_update0), .done(done0), .err(err0));

  ad9958_reg_writer #(.NIBBLE_LSB_FIRST(1'b0)) dut1 (
    .clock(clock), .reset(reset), .cmd(cif1),
    .spi_data(spi_data1), .spi_packs(spi_packs1), .spi_trigger(spi_trigger1),
    .spi_busy(spi_busy1), .io_update(io_update1), .done(done1), .err(err1));

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  packs;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int vectors = 0;
  int miscompares = 0;
  int nb_tab[25] = '{1, 3, 2, 3, 4, 2, 3, 2, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};

  function automatic exp_t model(input logic [4:0] a, input logic [31:0] d, input bit lsb_first);
    exp_t e;
    int n, m;
    logic [39:0] v;
    logic [39:0] mask;
    n    = nb_tab[a];
    m    = 2 * (n + 1);
    mask = (40'd1 << (8 * n)) - 40'd1;
    v    = ({35'd0, a} << (8 * n)) | ({8'd0, d} & mask);
    e.data  = '0;
    e.packs = 5'(m);
    for (int k = 0; k < m; k++) begin
      if (lsb_first) e.data[4*k +: 4]      = v[4*(m-1-k) +: 4];
      else           e.data[60 - 4*k +: 4] = v[4*(m-1-k) +: 4];
    end
    return e;
  endfunction

  always @(negedge clock) begin
    if (spi_trigger0) begin
      exp_t e;
      vectors++;
      if (q0.size() == 0) begin
        miscompares++;
        $display("FAIL trig0_unexpected: trigger with empty scoreboard, data %h", spi_data0);
      end else begin
        e = q0.pop_front();
        if (spi_data0 !== e.data || spi_packs0 !== e.packs) begin
          miscompares++;
          $display("FAIL frame0: got data %h packs %0d, want data %h packs %0d",
                   spi_data0, spi_packs0, e.data, e.packs);
        end
      end
    end
    if (spi_trigger1) begin
      exp_t e;
      vectors++;
      if (q1.size() == 0) begin
        miscompares++;
        $display("FAIL trig1_unexpected: trigger with empty scoreboard, data %h", spi_data1);
      end else begin
        e = q1.pop_front();
        if (spi_data1 !== e.data || spi_packs1 !== e.packs) begin
          miscompares++;
          $display("FAIL frame1: got data %h packs %0d, want data %h packs %0d",
                   spi_data1, spi_packs1, e.data, e.packs);
        end
      end
    end
  end

  // blen = 0 means spi_busy never rises (timeout path).
  task automatic do_cmd(input logic [4:0] a, input logic [31:0] d, input logic u, input int blen,
                        input logic [63:0] exp_data, input logic [4:0] exp_packs, input string name);
    bit bad;
    bit ready_seen;
    int trig_cyc, trig_cnt, busy_fall, busy_left, io_first, io_cnt;
    int done_cnt, done_cyc, err_cnt, err_cyc, want_done;
    bad = (a > 5'h18);
    ready_seen = 0;
    trig_cyc = -1; trig_cnt = 0; busy_fall = -1; busy_left = 0; io_first = -1; io_cnt = 0;
    done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
    if (!bad) q0.push_back('{data: exp_data, packs: exp_packs});
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (cif0.cmd_ready === 1'b1) begin
        ready_seen = 1;
        break;
      end
    end
    vectors++;
    if (!ready_seen) begin
      miscompares++;
      $display("FAIL %s_ready: cmd_ready %b after 50 cycles, want 1", name, cif0.cmd_ready);
      return;
    end
    cif0.cmd_valid = 1'b1; cif0.cmd_addr = a; cif0.cmd_data = d; cif0.cmd_update = u;
    @(posedge clock);
    #1 cif0.cmd_valid = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (spi_trigger0) begin
        trig_cnt++;
        if (trig_cyc < 0) trig_cyc = c;
      end
      if (io_update0) begin
        io_cnt++;
        if (io_first < 0) io_first = c;
      end
      if (done0) begin done_cnt++; done_cyc = c; end
      if (err0) begin err_cnt++; err_cyc = c; end
      if (blen > 0 && trig_cyc >= 0 && c == trig_cyc + 1) begin
        spi_busy0 = 1'b1;
        busy_left = blen;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          spi_busy0 = 1'b0;
          busy_fall = c;
        end
      end
      if (done_cnt > 0 || err_cnt > 0) break;
    end
    vectors++;
    if (bad) begin
      if (err_cnt != 1 || err_cyc != 0 || trig_cnt != 0 || done_cnt != 0) begin
        miscompares++;
        $display("FAIL %s_badaddr: err %0d at %0d trig %0d done %0d, want err 1 at 0 trig 0 done 0",
                 name, err_cnt, err_cyc, trig_cnt, done_cnt);
      end
    end else if (blen == 0) begin
      if (err_cnt != 1 || trig_cnt != 1 || err_cyc - trig_cyc != 16 || done_cnt != 0 || io_cnt != 0) begin
        miscompares++;
        $display("FAIL %s_timeout: err %0d trig %0d delay %0d done %0d io %0d, want 1 1 16 0 0",
                 name, err_cnt, trig_cnt, err_cyc - trig_cyc, done_cnt, io_cnt);
      end
    end else begin
      want_done = busy_fall + (u ? 4 : 0) + 2;
      if (trig_cyc != 2 || trig_cnt != 1) begin
        miscompares++;
        $display("FAIL %s_trigger: at %0d count %0d, want at 2 count 1", name, trig_cyc, trig_cnt);
      end
      vectors++;
      if (io_cnt != (u ? 4 : 0) || (u && io_first != busy_fall + 1)) begin
        miscompares++;
        $display("FAIL %s_ioupd: %0d cycles from %0d, want %0d from %0d",
                 name, io_cnt, io_first, u ? 4 : 0, busy_fall + 1);
      end
      vectors++;
      if (done_cnt != 1 || done_cyc != want_done || err_cnt != 0) begin
        miscompares++;
        $display("FAIL %s_done: %0d at %0d err %0d, want 1 at %0d err 0",
                 name, done_cnt, done_cyc, err_cnt, want_done);
      end
    end
    $display("cmd %s addr %h data %h upd %b: trig@%0d io %0d done@%0d err@%0d",
             name, a, d, u, trig_cyc, io_cnt, done_cyc, err_cyc);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      vectors++;
      if (spi_data0 !== 64'd0 || spi_packs0 !== 5'd0 || spi_trigger0 !== 1'b0 || io_update0 !== 1'b0 ||
          done0 !== 1'b0 || err0 !== 1'b0 || cif0.cmd_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_outputs: data %h packs %0d trig %b io %b done %b err %b ready %b, want all 0",
                 spi_data0, spi_packs0, spi_trigger0, io_update0, done0, err0, cif0.cmd_ready);
      end
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (cif0.cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_early: got %b want 0", cif0.cmd_ready);
    end
    @(negedge clock);
    vectors++;
    if (cif0.cmd_ready !== 1'b1 || cif1.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b/%b want 1/1", cif0.cmd_ready, cif1.cmd_ready);
    end
    $display("reset released, cmd_ready %b", cif0.cmd_ready);
  endtask

  task automatic test_write_no_update;
    do_cmd(5'h04, 32'h12345678, 1'b0, 40, 64'h0000_0087_6543_2140, 5'd10, "addr04");
  endtask

  task automatic test_write_update;
    do_cmd(5'h00, 32'h000000F0, 1'b1, 6, 64'h0000_0000_0000_0F00, 5'd4, "addr00_upd");
  endtask

  task automatic test_msb_first;
    bit seen_done;
    int trig_at;
    seen_done = 0;
    trig_at = -1;
    q1.push_back('{data: 64'h02AB_CD00_0000_0000, packs: 5'd6});
    @(negedge clock);
    cif1.cmd_valid = 1'b1; cif1.cmd_addr = 5'h02; cif1.cmd_data = 32'hFFFFABCD; cif1.cmd_update = 1'b0;
    @(posedge clock);
    #1 cif1.cmd_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (spi_trigger1 && trig_at < 0) trig_at = c;
      if (trig_at >= 0 && c == trig_at + 1) spi_busy1 = 1'b1;
      if (trig_at >= 0 && c == trig_at + 4) spi_busy1 = 1'b0;
      if (done1) begin seen_done = 1; break; end
    end
    vectors++;
    if (!seen_done) begin
      miscompares++;
      $display("FAIL msb_first_done: done %b within 60 cycles, want 1", seen_done);
    end
    $display("cmd msb_first addr 02 data ffffabcd: trig@%0d done %b", trig_at, seen_done);
  endtask

  task automatic test_errors;
    do_cmd(5'h19, 32'hDEADBEEF, 1'b1, 5, 64'd0, 5'd0, "badaddr19");
    do_cmd(5'h1F, 32'h00000001, 1'b0, 5, 64'd0, 5'd0, "badaddr1f");
    do_cmd(5'h0A, 32'hCAFEF00D, 1'b1, 0, model(5'h0A, 32'hCAFEF00D, 1'b1).data, 5'd10, "timeout");
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [4:0] a;
    logic [31:0] d;
    logic u;
    for (int i = 0; i < 6; i++) begin
      a = 5'($urandom_range(0, 24));
      d = $urandom;
      u = 1'($urandom_range(0, 1));
      e = model(a, d, 1'b1);
      do_cmd(a, d, u, $urandom_range(1, 10), e.data, e.packs, $sformatf("b2b%0d", i));
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bit trig_seen;
    trig_seen = 0;
    e = model(5'h08, 32'hA5A55A5A, 1'b1);
    q0.push_back(e);
    @(negedge clock);
    cif0.cmd_valid = 1'b1; cif0.cmd_addr = 5'h08; cif0.cmd_data = 32'hA5A55A5A; cif0.cmd_update = 1'b1;
    @(posedge clock);
    #1 cif0.cmd_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (spi_trigger0) begin trig_seen = 1; break; end
    end
    @(negedge clock);
    spi_busy0 = 1'b1;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (!trig_seen || spi_data0 !== 64'd0 || spi_packs0 !== 5'd0 || spi_trigger0 !== 1'b0 ||
        io_update0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0 || cif0.cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: trig %b data %h packs %0d io %b done %b err %b ready %b, want trig 1 rest 0",
               trig_seen, spi_data0, spi_packs0, io_update0, done0, err0, cif0.cmd_ready);
    end
    spi_busy0 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    $display("reset asserted mid-transfer, outputs data %h packs %0d", spi_data0, spi_packs0);
    e = model(5'h03, 32'h00ABCDEF, 1'b1);
    do_cmd(5'h03, 32'h00ABCDEF, 1'b1, 5, e.data, e.packs, "after_reset");
  endtask

  initial begin
    cif0.cmd_valid = 1'b0; cif0.cmd_addr = '0; cif0.cmd_data = '0; cif0.cmd_update = 1'b0;
    cif1.cmd_valid = 1'b0; cif1.cmd_addr = '0; cif1.cmd_data = '0; cif1.cmd_update = 1'b0;
    test_reset();
    test_write_no_update();
    test_write_update();
    test_msb_first();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clock);
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, want 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units, want completion");
    $fatal(1, "timeout");
  end
endmodule
